// File: rtl/pkt_rr_arbiter.sv
// Two-input packet-granular round-robin arbiter onto one byte stream.
// Oversized packets are cut at MAX_LEN with an error flag and their tail is dropped.
module pkt_rr_arbiter #(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din0,
    input  logic       din0_sop,
    input  logic       din0_eop,
    input  logic       din0_vld,
    output logic       din0_rdy,
    input  logic [7:0] din1,
    input  logic       din1_sop,
    input  logic       din1_eop,
    input  logic       din1_vld,
    output logic       din1_rdy,
    output logic [7:0] dout,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_vld,
    output logic       dout_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic             gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_sop_q, dout_sop_d;
    logic             dout_eop_q, dout_eop_d;
    logic             dout_vld_q, dout_vld_d;
    logic             dout_err_q, dout_err_d;

    logic       req0, req1;
    logic [7:0] sel_din;
    logic       sel_eop;
    logic       sel_vld;

    assign req0    = din0_vld & din0_sop;
    assign req1    = din1_vld & din1_sop;
    assign sel_din = gnt_q ? din1     : din0;
    assign sel_eop = gnt_q ? din1_eop : din0_eop;
    assign sel_vld = gnt_q ? din1_vld : din0_vld;

    // In IDLE only stray non-sop bytes are accepted (and thrown away).
    always_comb begin
        din0_rdy = 1'b0;
        din1_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                din0_rdy = din0_vld & ~din0_sop;
                din1_rdy = din1_vld & ~din1_sop;
            end
            BUSY, DROP: begin
                din0_rdy = ~gnt_q;
                din1_rdy = gnt_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        gap_d      = 1'b0;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_sop_d = 1'b0;
        dout_eop_d = 1'b0;
        dout_vld_d = 1'b0;
        dout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // gap_q blocks arbitration for the first IDLE cycle after a packet
                if (!gap_q && (req0 || req1)) begin
                    gnt_d   = (req0 && req1) ? ~last_gnt_q : req1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (sel_vld) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    dout_d     = sel_din;
                    dout_vld_d = 1'b1;
                    dout_sop_d = (cnt_q == '0);
                    if (sel_eop) begin
                        dout_eop_d = 1'b1;
                        last_gnt_d = gnt_q;
                        gap_d      = 1'b1;
                        state_d    = IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        dout_eop_d = 1'b1;
                        dout_err_d = 1'b1;
                        state_d    = DROP;
                    end
                end
            end
            DROP: begin
                if (sel_vld && sel_eop) begin
                    last_gnt_d = gnt_q;
                    gap_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            gap_q      <= 1'b0;
            cnt_q      <= '0;
            dout_q     <= 8'h00;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_vld_q <= dout_vld_d;
            dout_err_q <= dout_err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout_vld = dout_vld_q;
    assign dout_err = dout_err_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter: per-source byte scripts are replayed with
// handshaking and the output stream is compared against a packet-level reference model.
module tb_pkt_rr_arbiter;

    localparam int MAX_LEN = 64;
    localparam int CNT_W   = 7;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         pre_gap;
    } beat_t;

    typedef struct {
        logic       vld, sop, eop, err;
        logic [7:0] d;
        logic       rdy0, rdy1;
        logic       m_vld, m_sop, m_eop, m_err;
        logic [7:0] m_d;
        logic       m_rdy0, m_rdy1;
    } obs_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
    } out_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [2];
    logic       sop [2];
    logic       eop [2];
    logic       vld [2];
    logic       rdy0, rdy1;
    logic [7:0] dout;
    logic       dout_sop, dout_eop, dout_vld, dout_err;
    logic       m_rdy0, m_rdy1;
    logic [7:0] m_dout;
    logic       m_sop, m_eop, m_vld, m_err;

    beat_t stim [2][0:1023];
    int    stim_len [2];
    obs_t  obs [$];
    out_t  exp_q [$];
    out_t  got_q [$];
    int    checks = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    pkt_rr_arbiter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .din0(din[0]), .din0_sop(sop[0]), .din0_eop(eop[0]), .din0_vld(vld[0]), .din0_rdy(rdy0),
        .din1(din[1]), .din1_sop(sop[1]), .din1_eop(eop[1]), .din1_vld(vld[1]), .din1_rdy(rdy1),
        .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld), .dout_err(dout_err)
    );

    pkt_rr_arbiter #(.MAX_LEN(1), .CNT_W(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n),
        .din0(din[0]), .din0_sop(sop[0]), .din0_eop(eop[0]), .din0_vld(vld[0]), .din0_rdy(m_rdy0),
        .din1(din[1]), .din1_sop(sop[1]), .din1_eop(eop[1]), .din1_vld(vld[1]), .din1_rdy(m_rdy1),
        .dout(m_dout), .dout_sop(m_sop), .dout_eop(m_eop), .dout_vld(m_vld), .dout_err(m_err)
    );

    task automatic clear_stim();
        stim_len[0] = 0;
        stim_len[1] = 0;
    endtask

    task automatic do_reset();
        for (int n = 0; n < 2; n++) begin
            vld[n] = 1'b0; sop[n] = 1'b0; eop[n] = 1'b0; din[n] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add_beat(input int n, input logic [7:0] d, input logic s, input logic e, input int g);
        beat_t b;
        b.d = d; b.sop = s; b.eop = e; b.pre_gap = g;
        stim[n][stim_len[n]] = b;
        stim_len[n]++;
    endtask

    task automatic add_packet(input int n, input int len, input int gap_pct, input int mid_sop_pct);
        logic s;
        int   g;
        for (int j = 0; j < len; j++) begin
            s = (j == 0) || (int'($urandom_range(99)) < mid_sop_pct);
            g = (j > 0 && int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
            add_beat(n, 8'($urandom_range(255)), s, (j == len - 1), g);
        end
    endtask

    // Packet-level model: whole packets, sources alternate starting with input 0
    // (both sources keep a packet pending in every multi-source scenario), cut at max_len.
    task automatic build_expected(input int max_len);
        int   ps [2][0:255];
        int   pe [2][0:255];
        int   np [2];
        int   k [2];
        bit   in_pkt;
        int   turn, n, len, fwd;
        out_t o;
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            np[s] = 0;
            in_pkt = 0;
            for (int i = 0; i < stim_len[s]; i++) begin
                if (!in_pkt && stim[s][i].sop) begin ps[s][np[s]] = i; in_pkt = 1; end
                if (in_pkt && stim[s][i].eop) begin pe[s][np[s]] = i; np[s]++; in_pkt = 0; end
            end
        end
        k[0] = 0; k[1] = 0; turn = 0;
        while (k[0] < np[0] || k[1] < np[1]) begin
            n   = (k[turn] < np[turn]) ? turn : 1 - turn;
            len = pe[n][k[n]] - ps[n][k[n]] + 1;
            fwd = (len > max_len) ? max_len : len;
            for (int j = 0; j < fwd; j++) begin
                o.d   = stim[n][ps[n][k[n]] + j].d;
                o.sop = (j == 0);
                o.eop = (j == fwd - 1);
                o.err = (len > max_len) && (j == fwd - 1);
                exp_q.push_back(o);
            end
            k[n]++;
            turn = 1 - n;
        end
    endtask

    task automatic run_traffic(input int max_cycles, output bit timed_out);
        int   idx [2];
        int   wait_c [2];
        bit   pres [2];
        bit   acc [2];
        int   drain, cyc;
        obs_t o;
        obs.delete();
        for (int n = 0; n < 2; n++) begin
            idx[n] = 0;
            wait_c[n] = (stim_len[n] > 0) ? stim[n][0].pre_gap : 0;
        end
        drain = 0; cyc = 0; timed_out = 0;
        while (drain < 6) begin
            if (cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            for (int n = 0; n < 2; n++) begin
                pres[n] = (idx[n] < stim_len[n]) && (wait_c[n] == 0);
                vld[n]  = pres[n];
                if (pres[n]) begin
                    din[n] = stim[n][idx[n]].d;
                    sop[n] = stim[n][idx[n]].sop;
                    eop[n] = stim[n][idx[n]].eop;
                end else begin
                    sop[n] = 1'b0;
                    eop[n] = 1'b0;
                end
            end
            @(negedge clk);
            o.vld = dout_vld; o.sop = dout_sop; o.eop = dout_eop; o.err = dout_err; o.d = dout;
            o.rdy0 = rdy0; o.rdy1 = rdy1;
            o.m_vld = m_vld; o.m_sop = m_sop; o.m_eop = m_eop; o.m_err = m_err; o.m_d = m_dout;
            o.m_rdy0 = m_rdy0; o.m_rdy1 = m_rdy1;
            obs.push_back(o);
            acc[0] = pres[0] && rdy0;
            acc[1] = pres[1] && rdy1;
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    idx[n]++;
                    if (idx[n] < stim_len[n]) wait_c[n] = stim[n][idx[n]].pre_gap;
                end else if (!pres[n] && wait_c[n] > 0) begin
                    wait_c[n]--;
                end
            end
            if (idx[0] >= stim_len[0] && idx[1] >= stim_len[1]) drain++;
            cyc++;
        end
        for (int n = 0; n < 2; n++) begin
            vld[n] = 1'b0; sop[n] = 1'b0; eop[n] = 1'b0;
        end
    endtask

    task automatic collect(input int which);
        out_t o;
        got_q.delete();
        for (int i = 0; i < obs.size(); i++) begin
            if (which == 0 && obs[i].vld) begin
                o.d = obs[i].d; o.sop = obs[i].sop; o.eop = obs[i].eop; o.err = obs[i].err;
                got_q.push_back(o);
            end else if (which == 1 && obs[i].m_vld) begin
                o.d = obs[i].m_d; o.sop = obs[i].m_sop; o.eop = obs[i].m_eop; o.err = obs[i].m_err;
                got_q.push_back(o);
            end
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            vld[n] = 1'b1; sop[n] = 1'b1; eop[n] = 1'b0; din[n] = 8'hA5;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({dout_vld, dout_sop, dout_eop, dout_err} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected 0000", {dout_vld, dout_sop, dout_eop, dout_err}); else passed++;
        checks++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", dout); else passed++;
        do_reset();
        #1;
        checks++; if ({rdy0, rdy1} !== 2'b00) $display("[TB] FAIL reset_rdy: got %b expected 00", {rdy0, rdy1}); else passed++;
        vld[0] = 1'b1; sop[0] = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b0) $display("[TB] FAIL idle_req_rdy: got %b expected 0", rdy0); else passed++;
        sop[0] = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b1) $display("[TB] FAIL idle_stray_rdy: got %b expected 1", rdy0); else passed++;
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_source();
        bit to;
        int first;
        clear_stim();
        do_reset();
        for (int j = 0; j < 10; j++) add_beat(0, (j < 5) ? 8'hDD : 8'hEE, (j == 0), (j == 9), 0);
        run_traffic(200, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL single_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL single_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL single_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        first = -1;
        for (int i = obs.size() - 1; i >= 0; i--) if (obs[i].vld) first = i;
        checks++; if (first != 2) $display("[TB] FAIL single_latency: got %0d expected 2", first); else passed++;
        for (int i = 2; i < 12 && i < obs.size(); i++) begin
            checks++; if (obs[i].vld !== 1'b1) $display("[TB] FAIL single_burst%0d: got %b expected 1", i, obs[i].vld); else passed++;
        end
        for (int i = 0; i < obs.size(); i++) begin
            checks++; if (obs[i].rdy1 !== 1'b0) $display("[TB] FAIL single_rdy1_%0d: got %b expected 0", i, obs[i].rdy1); else passed++;
        end
    endtask

    task automatic test_tie();
        bit to;
        int last_eop;
        clear_stim();
        do_reset();
        add_packet(0, 4, 0, 0);
        add_packet(0, 4, 0, 0);
        add_packet(1, 4, 0, 0);
        run_traffic(200, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL tie_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL tie_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL tie_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        last_eop = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].vld && obs[i].sop && last_eop >= 0) begin
                checks++; if (i - last_eop - 1 < 2) $display("[TB] FAIL tie_gap: got %0d idle cycles expected >=2", i - last_eop - 1); else passed++;
            end
            if (obs[i].vld && obs[i].eop) last_eop = i;
        end
    endtask

    task automatic test_truncate();
        bit to;
        int nv;
        clear_stim();
        do_reset();
        for (int j = 0; j < 72; j++) add_beat(1, 8'h22, (j == 0), (j == 71), 0);
        add_packet(1, 3, 0, 0);
        run_traffic(400, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL trunc_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL trunc_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL trunc_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        nv = 0;
        for (int i = 0; i < obs.size(); i++) if (obs[i].vld) nv++;
        checks++; if (nv != 67) $display("[TB] FAIL trunc_vld_count: got %0d expected 67", nv); else passed++;
    endtask

    task automatic test_stall();
        bit to;
        int s, e, idle;
        clear_stim();
        do_reset();
        for (int j = 0; j < 8; j++) add_beat(0, 8'(8'h40 + j), (j == 0), (j == 7), (j == 4) ? 3 : 0);
        add_packet(1, 4, 0, 0);
        run_traffic(200, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL stall_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL stall_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        s = -1; e = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (s < 0 && obs[i].vld && obs[i].sop) s = i;
            if (s >= 0 && e < 0 && obs[i].vld && obs[i].eop) e = i;
        end
        idle = 0;
        for (int i = s; i >= 0 && i <= e; i++) if (!obs[i].vld) idle++;
        checks++; if (idle != 3 || e < 0) $display("[TB] FAIL stall_gap: got %0d expected 3", idle); else passed++;
        for (int i = 0; i <= e; i++) begin
            checks++; if (obs[i].rdy1 !== 1'b0) $display("[TB] FAIL stall_rdy1_%0d: got %b expected 0", i, obs[i].rdy1); else passed++;
        end
    endtask

    task automatic test_stray();
        bit to;
        int first, nv;
        clear_stim();
        do_reset();
        add_beat(1, 8'h11, 1'b0, 1'b0, 0);
        add_beat(1, 8'h12, 1'b0, 1'b1, 0);
        add_beat(1, 8'h13, 1'b0, 1'b0, 0);
        add_beat(1, 8'h5A, 1'b1, 1'b1, 0);
        run_traffic(100, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL stray_timeout: got 1 expected 0"); else passed++;
        checks++; if (obs[0].rdy1 !== 1'b1) $display("[TB] FAIL stray_flush_rdy: got %b expected 1", obs[0].rdy1); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL stray_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL stray_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        first = -1; nv = 0;
        for (int i = obs.size() - 1; i >= 0; i--) if (obs[i].vld) begin first = i; nv++; end
        checks++; if (first != 5) $display("[TB] FAIL stray_latency: got %0d expected 5", first); else passed++;
        checks++; if (nv != 1) $display("[TB] FAIL stray_vld_count: got %0d expected 1", nv); else passed++;
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_stim();
        do_reset();
        vld[0] = 1'b1; din[0] = 8'h30; sop[0] = 1'b1; eop[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            din[0] = 8'(8'h31 + i);
            sop[0] = 1'b0;
        end
        checks++; if ({dout_vld, dout} !== {1'b1, 8'h34}) $display("[TB] FAIL rstmid_byte5: got %h expected 134", {dout_vld, dout}); else passed++;
        rst_n = 1'b0;
        vld[0] = 1'b0;
        #1;
        checks++; if ({dout_vld, dout_sop, dout_eop, dout_err} !== 4'b0000) $display("[TB] FAIL rstmid_flags: got %b expected 0000", {dout_vld, dout_sop, dout_eop, dout_err}); else passed++;
        checks++; if (dout !== 8'h00) $display("[TB] FAIL rstmid_dout: got %h expected 00", dout); else passed++;
        checks++; if ({rdy0, rdy1} !== 2'b00) $display("[TB] FAIL rstmid_rdy: got %b expected 00", {rdy0, rdy1}); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        add_packet(0, MAX_LEN, 0, 0);
        run_traffic(300, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL rstmid_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL rstmid_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL rstmid_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_maxlen1();
        bit to;
        clear_stim();
        do_reset();
        add_packet(0, 3, 0, 0);
        add_packet(0, 1, 0, 0);
        run_traffic(100, to);
        checks++; if (to) $display("[TB] FAIL max1_timeout: got 1 expected 0"); else passed++;
        build_expected(1);
        collect(1);
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL max1_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL max1_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL max1_main_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL max1_main_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_random();
        bit         to;
        int         k, last_eop;
        logic [7:0] exp_d;
        clear_stim();
        do_reset();
        for (int p = 0; p < 6; p++) begin
            add_packet(0, int'($urandom_range(80, 1)), 30, 10);
            add_packet(1, int'($urandom_range(80, 1)), 30, 10);
        end
        run_traffic(6000, to);
        build_expected(MAX_LEN);
        collect(0);
        checks++; if (to) $display("[TB] FAIL rand_timeout: got 1 expected 0"); else passed++;
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL rand_len: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
        end
        k = 0; last_eop = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].vld) begin
                if (obs[i].sop && last_eop >= 0) begin
                    checks++; if (i - last_eop - 1 < 2) $display("[TB] FAIL rand_gap: got %0d idle cycles expected >=2", i - last_eop - 1); else passed++;
                end
                if (obs[i].eop) last_eop = i;
                k++;
            end else begin
                checks++; if ({obs[i].sop, obs[i].eop, obs[i].err} !== 3'b000) $display("[TB] FAIL rand_idle_flags: got %b expected 000", {obs[i].sop, obs[i].eop, obs[i].err}); else passed++;
                exp_d = (k == 0 || k > exp_q.size()) ? 8'h00 : exp_q[k-1].d;
                if (k <= exp_q.size()) begin
                    checks++; if (obs[i].d !== exp_d) $display("[TB] FAIL rand_hold: got %h expected %h", obs[i].d, exp_d); else passed++;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_source();
        test_tie();
        test_truncate();
        test_stall();
        test_stray();
        test_reset_mid();
        test_maxlen1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
